hexaram_wr_arb: RTL and testbench

HEXARAM_WR_ARB -- requirements
Module: hexaram_wr_arb

---
 rtl/hexaram_wr_arb_pkg.sv | 12 +
 rtl/hexaram_wr_arb_rr_pick2.sv | 39 +++
 rtl/hexaram_wr_arb.sv | 184 ++++++++++++++++++
 tb/tb_hexaram_wr_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hexaram_wr_arb_pkg.sv
// Shared widths and FSM encoding for the hexa-port RAM write arbiter.
package hexaram_wr_arb_pkg;

    localparam int W = 8;
    localparam int M = 16;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/hexaram_wr_arb_rr_pick2.sv
// Combinational two-winner round-robin picker: scans from ptr, first valid
// requester wins A, second wins B.
module rr_pick2 (
    input  logic [3:0] valid,
    input  logic [1:0] ptr,
    output logic [1:0] idx_a,
    output logic       vld_a,
    output logic [1:0] idx_b,
    output logic       vld_b
);

    logic [1:0] cand_s;

    // Walk the four requesters in rotating order starting at ptr
    always_comb begin
        idx_a  = 2'd0;
        vld_a  = 1'b0;
        idx_b  = 2'd0;
        vld_b  = 1'b0;
        cand_s = ptr;
        for (int k = 0; k < 4; k++) begin
            cand_s = ptr + k[1:0];
            if (valid[cand_s]) begin
                if (!vld_a) begin
                    idx_a = cand_s;
                    vld_a = 1'b1;
                end else if (!vld_b) begin
                    idx_b = cand_s;
                    vld_b = 1'b1;
                end else begin
                    vld_b = vld_b;
                end
            end else begin
                cand_s = cand_s;
            end
        end
    end

endmodule

// File: rtl/hexaram_wr_arb.sv
// Four-requester, two-port write arbiter for a six-port RAM with a starvation
// guard that periodically opens a one-cycle write-free window for readers.
module hexaram_wr_arb
    import hexaram_wr_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req_valid,
    input  logic [4*W-1:0] req_addr,
    input  logic [4*W-1:0] req_data,
    output logic [3:0]     req_ready,
    input  logic [3:0]     rd_req,
    output logic           we_a,
    output logic           we_b,
    output logic [W-1:0]   addr_a,
    output logic [W-1:0]   addr_b,
    output logic [W-1:0]   data_a,
    output logic [W-1:0]   data_b,
    output logic [3:0]     rd_vld,
    output logic           state_hold
);

    localparam logic [2:0] LIM_C = 3'(STARVE_LIM);

    arb_state_t   state_r;
    arb_state_t   state_nxt_s;
    logic [1:0]   rr_ptr_r;
    logic [2:0]   cnt_r;
    logic [2:0]   cnt_nxt_s;
    logic [1:0]   idx_a_s;
    logic [1:0]   idx_b_s;
    logic         vld_a_s;
    logic         vld_b_s;
    logic         same_addr_s;
    logic         arb_en_s;
    logic         grant_a_s;
    logic         grant_b_s;
    logic         starve_s;
    logic [3:0]   blocked_s;
    logic [W-1:0] addr_arr_s [4];
    logic [W-1:0] data_arr_s [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        assign addr_arr_s[g] = req_addr[g*W +: W];
        assign data_arr_s[g] = req_data[g*W +: W];
    end

    rr_pick2 u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .idx_a (idx_a_s),
        .vld_a (vld_a_s),
        .idx_b (idx_b_s),
        .vld_b (vld_b_s)
    );

    assign same_addr_s = vld_a_s & vld_b_s & (addr_arr_s[idx_a_s] == addr_arr_s[idx_b_s]);
    assign grant_a_s   = arb_en_s & vld_a_s;
    assign grant_b_s   = arb_en_s & vld_b_s & ~same_addr_s;
    assign blocked_s   = {we_b, we_a, we_b, we_a};
    // Only reads that this cycle's grants would actually block count as starving
    assign starve_s    = |(rd_req & {grant_b_s, grant_a_s, grant_b_s, grant_a_s});

    // Grant decode back to requester positions
    always_comb begin
        req_ready = 4'b0000;
        if (grant_a_s) begin
            req_ready[idx_a_s] = 1'b1;
        end else begin
            req_ready = req_ready;
        end
        if (grant_b_s) begin
            req_ready[idx_b_s] = 1'b1;
        end else begin
            req_ready = req_ready;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and starve counter next value
    always_comb begin
        state_nxt_s = ARB;
        cnt_nxt_s   = 3'd0;
        case (state_r)
            ARB: begin
                if (starve_s) begin
                    cnt_nxt_s = cnt_r + 3'd1;
                end else begin
                    cnt_nxt_s = 3'd0;
                end
                if (cnt_nxt_s == LIM_C) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ARB;
                end
            end
            HOLD: begin
                state_nxt_s = ARB;
                cnt_nxt_s   = 3'd0;
            end
            default: begin
                state_nxt_s = ARB;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // FSM outputs; grants are suppressed during reset and the hold window
    always_comb begin
        case (state_r)
            ARB: begin
                arb_en_s   = rst_n;
                state_hold = 1'b0;
            end
            HOLD: begin
                arb_en_s   = 1'b0;
                state_hold = 1'b1;
            end
            default: begin
                arb_en_s   = 1'b0;
                state_hold = 1'b0;
            end
        endcase
    end

    // Starve counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 3'd0;
            rr_ptr_r <= 2'd0;
        end else begin
            cnt_r <= (state_nxt_s == HOLD) ? 3'd0 : cnt_nxt_s;
            if (grant_b_s) begin
                rr_ptr_r <= idx_b_s + 2'd1;
            end else if (grant_a_s) begin
                rr_ptr_r <= idx_a_s + 2'd1;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Registered RAM write ports and read-valid flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a   <= 1'b0;
            we_b   <= 1'b0;
            addr_a <= {W{1'b0}};
            addr_b <= {W{1'b0}};
            data_a <= {W{1'b0}};
            data_b <= {W{1'b0}};
            rd_vld <= 4'b0000;
        end else begin
            we_a   <= grant_a_s;
            we_b   <= grant_b_s;
            rd_vld <= rd_req & ~blocked_s;
            if (grant_a_s) begin
                addr_a <= addr_arr_s[idx_a_s];
                data_a <= data_arr_s[idx_a_s];
            end else begin
                addr_a <= addr_a;
                data_a <= data_a;
            end
            if (grant_b_s) begin
                addr_b <= addr_arr_s[idx_b_s];
                data_b <= data_arr_s[idx_b_s];
            end else begin
                addr_b <= addr_b;
                data_b <= data_b;
            end
        end
    end

endmodule

// File: tb/tb_hexaram_wr_arb.sv
// Self-checking bench for hexaram_wr_arb: directed scenarios plus randomized
// traffic against a list-based reference model.
module tb_hexaram_wr_arb;
    import hexaram_wr_arb_pkg::*;

    localparam int LIM = 4;
    localparam int OW  = 2 + 4*W + 4 + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req_valid = 4'b0000;
    logic [4*W-1:0] req_addr = '0;
    logic [4*W-1:0] req_data = '0;
    logic [3:0]     rd_req = 4'b0000;
    logic [3:0]     req_ready;
    logic           we_a, we_b;
    logic [W-1:0]   addr_a, addr_b, data_a, data_b;
    logic [3:0]     rd_vld;
    logic           state_hold;
    logic [OW-1:0]  dut_outs;

    int tests = 0;
    int fails = 0;

    // reference model state
    int           m_ptr, m_cnt, m_ga, m_gb;
    bit           m_hold;
    logic         m_we_a, m_we_b;
    logic [W-1:0] m_addr_a, m_addr_b, m_data_a, m_data_b;
    logic [3:0]   m_rd_vld, m_ready;

    always #5 clk = ~clk;

    hexaram_wr_arb #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .rd_req(rd_req),
        .we_a(we_a), .we_b(we_b), .addr_a(addr_a), .addr_b(addr_b),
        .data_a(data_a), .data_b(data_b), .rd_vld(rd_vld), .state_hold(state_hold)
    );

    assign dut_outs = {we_a, we_b, addr_a, addr_b, data_a, data_b, rd_vld, state_hold};

    function automatic logic [W-1:0] lane(input logic [4*W-1:0] bus, input int i);
        return bus[i*W +: W];
    endfunction

    function automatic logic [4*W-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic logic [OW-1:0] model_outs();
        return {m_we_a, m_we_b, m_addr_a, m_addr_b, m_data_a, m_data_b, m_rd_vld, m_hold};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_ga = -1; m_gb = -1; m_hold = 1'b0;
        m_we_a = 1'b0; m_we_b = 1'b0;
        m_addr_a = '0; m_addr_b = '0; m_data_a = '0; m_data_b = '0;
        m_rd_vld = 4'b0000; m_ready = 4'b0000;
    endtask

    // Who would be granted this cycle given the current inputs
    task automatic model_grants();
        int found[$];
        m_ga = -1; m_gb = -1; m_ready = 4'b0000;
        if (rst_n && !m_hold) begin
            for (int k = 0; k < 4; k++) begin
                if (req_valid[(m_ptr + k) % 4]) found.push_back((m_ptr + k) % 4);
            end
            if (found.size() > 0) m_ga = found[0];
            if (found.size() > 1 && lane(req_addr, found[1]) != lane(req_addr, found[0]))
                m_gb = found[1];
        end
        if (m_ga >= 0) m_ready[m_ga] = 1'b1;
        if (m_gb >= 0) m_ready[m_gb] = 1'b1;
    endtask

    // Advance the model across one rising edge
    task automatic model_commit();
        bit st;
        st = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_rd_vld[c] = rd_req[c] & ~((c % 2 == 0) ? m_we_a : m_we_b);
            if (rd_req[c] && (((c % 2 == 0) && m_ga >= 0) || ((c % 2 == 1) && m_gb >= 0))) st = 1'b1;
        end
        m_we_a = (m_ga >= 0);
        m_we_b = (m_gb >= 0);
        if (m_ga >= 0) begin m_addr_a = lane(req_addr, m_ga); m_data_a = lane(req_data, m_ga); end
        if (m_gb >= 0) begin m_addr_b = lane(req_addr, m_gb); m_data_b = lane(req_data, m_gb); end
        if (m_gb >= 0) m_ptr = (m_gb + 1) % 4;
        else if (m_ga >= 0) m_ptr = (m_ga + 1) % 4;
        if (m_hold) begin
            m_hold = 1'b0;
            m_cnt  = 0;
        end else begin
            m_cnt = st ? m_cnt + 1 : 0;
            if (m_cnt == LIM) begin
                m_hold = 1'b1;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [4*W-1:0] a,
                         input logic [4*W-1:0] d, input logic [3:0] r);
        @(negedge clk);
        req_valid = v; req_addr = a; req_data = d; rd_req = r;
        #1;
        model_grants();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 4'b0000; rd_req = 4'b0000; req_addr = '0; req_data = '0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        model_grants();
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b1111; rd_req = 4'b1111;
        #2;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tests++;
        if (dut_outs !== '0) begin
            fails++; $display("FAIL reset_outs: got %h want 0", dut_outs);
        end
        do_reset();
        #1;
        tests++;
        if (dut_outs !== model_outs()) begin
            fails++; $display("FAIL after_reset_outs: got %h want %h", dut_outs, model_outs());
        end
    endtask

    task automatic test_pair();
        do_reset();
        drive(4'b0101, pack4(3, 0, 9, 0), pack4(8'h11, 0, 8'h22, 0), 4'b0000);
        tests++;
        if (req_ready !== 4'b0101) begin
            fails++; $display("FAIL pair_ready: got %b want 0101", req_ready);
        end
        tick();
        #1;
        tests++;
        if ({we_a, addr_a, data_a, we_b, addr_b, data_b} !== {1'b1, 8'd3, 8'h11, 1'b1, 8'd9, 8'h22}) begin
            fails++; $display("FAIL pair_ports: got a=%b/%0d/%h b=%b/%0d/%h want a=1/3/11 b=1/9/22",
                              we_a, addr_a, data_a, we_b, addr_b, data_b);
        end
        // pointer now 3: all-valid must start at requester 3
        drive(4'b1111, pack4(1, 2, 3, 4), pack4(0, 0, 0, 0), 4'b0000);
        tests++;
        if (req_ready !== 4'b1001) begin
            fails++; $display("FAIL pair_ptr3: got %b want 1001", req_ready);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0011; exp_seq[1] = 4'b1100; exp_seq[2] = 4'b0011;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(4'b1111, pack4(10, 11, 12, 13), pack4(n, n, n, n), 4'b0000);
            tests++;
            if (req_ready !== exp_seq[n] || req_ready !== m_ready) begin
                fails++; $display("FAIL rr_cycle%0d: got %b want %b", n, req_ready, exp_seq[n]);
            end
            tick();
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        drive(4'b0001, pack4(7, 0, 0, 0), '0, 4'b0000);
        tick();
        // pointer now 1; requesters 1 and 2 collide on address 5
        drive(4'b0110, pack4(0, 5, 5, 0), pack4(0, 8'hAA, 8'hBB, 0), 4'b0000);
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++; $display("FAIL same_addr_first: got %b want 0010", req_ready);
        end
        tick();
        drive(4'b0100, pack4(0, 5, 5, 0), pack4(0, 8'hAA, 8'hBB, 0), 4'b0000);
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++; $display("FAIL same_addr_retry: got %b want 0100", req_ready);
        end
        tests++;
        if ({we_a, we_b, addr_a, data_a} !== {1'b1, 1'b0, 8'd5, 8'hAA}) begin
            fails++; $display("FAIL same_addr_port: got %b%b %0d %h want 10 5 aa", we_a, we_b, addr_a, data_a);
        end
        tick();
    endtask

    task automatic test_starve();
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            drive(4'b0001, pack4(n, 0, 0, 0), pack4(n + 32, 0, 0, 0), 4'b0001);
            tests++;
            if (dut_outs !== model_outs() || req_ready !== m_ready) begin
                fails++; $display("FAIL starve_model_c%0d: got %h/%b want %h/%b",
                                  n, dut_outs, req_ready, model_outs(), m_ready);
            end
            if (n <= 4) begin
                tests++;
                if (state_hold !== 1'b0 || req_ready !== 4'b0001) begin
                    fails++; $display("FAIL starve_pre_c%0d: got hold=%b rdy=%b want 0/0001", n, state_hold, req_ready);
                end
            end else if (n == 5) begin
                tests++;
                if (state_hold !== 1'b1 || req_ready !== 4'b0000) begin
                    fails++; $display("FAIL starve_hold: got hold=%b rdy=%b want 1/0000", state_hold, req_ready);
                end
            end else if (n == 6) begin
                tests++;
                if (we_a !== 1'b0 || state_hold !== 1'b0) begin
                    fails++; $display("FAIL starve_gap: got we_a=%b hold=%b want 0/0", we_a, state_hold);
                end
            end else if (n == 7) begin
                tests++;
                if (rd_vld[0] !== 1'b1) begin
                    fails++; $display("FAIL starve_read: got rd_vld=%b want bit0 set", rd_vld);
                end
            end
            tick();
        end
    endtask

    task automatic test_other_ports();
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            drive(4'b0001, pack4(n, 0, 0, 0), pack4(n, 0, 0, 0), 4'b1010);
            if (n >= 2) begin
                tests++;
                if (rd_vld !== 4'b1010 || state_hold !== 1'b0) begin
                    fails++; $display("FAIL other_ports_c%0d: got rd_vld=%b hold=%b want 1010/0", n, rd_vld, state_hold);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4*W-1:0] a, d;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int j = 0; j < 4; j++) begin
                a[j*W +: W] = W'($urandom_range(0, 3));
                d[j*W +: W] = W'($urandom);
            end
            drive(4'($urandom_range(0, 15)), a, d, 4'($urandom_range(0, 15)));
            tests++;
            if (req_ready !== m_ready || dut_outs !== model_outs()) begin
                fails++; $display("FAIL random_c%0d: got %b/%h want %b/%h", n, req_ready, dut_outs, m_ready, model_outs());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            drive(4'b1111, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'b0011);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({we_a, we_b, rd_vld, req_ready} !== 10'b0) begin
            fails++; $display("FAIL async_reset_drop: got we=%b%b rd_vld=%b rdy=%b want zeros", we_a, we_b, rd_vld, req_ready);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        req_valid = 4'b1111; req_addr = pack4(1, 2, 3, 4); rd_req = 4'b0000;
        #1;
        model_grants();
        tests++;
        if (req_ready !== 4'b0011 || req_ready !== m_ready) begin
            fails++; $display("FAIL async_reset_restart: got %b want 0011", req_ready);
        end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pair();
        test_round_robin();
        test_same_addr();
        test_starve();
        test_other_ports();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, limit 200000 time units");
        $fatal(1);
    end

endmodule
